// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_pkg
//  Description : Shared sizing constants for the sequential shift-add
//                multiplier datapath and its iteration counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

  // Default operand width; the product is twice this wide.
  localparam int MUL_WIDTH  = 32;

  // Counter width that can still represent MUL_WIDTH itself.
  localparam int MUL_CNT_W  = $clog2(MUL_WIDTH) + 1;

  // Width of the full double-length product.
  localparam int MUL_PROD_W = 2 * MUL_WIDTH;

  // Counter width for an arbitrary operand width w (count must reach w).
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_iter_counter.sv
`default_nettype none
// ============================================================================
//  Module      : mul_iter_counter
//  Description : Iteration counter for the shift-add multiplier. Counts incr
//                pulses up to WIDTH and saturates there, flags less32 while
//                the count is below WIDTH and raises a sticky done.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_iter_counter
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic incr,
  output logic less32,
  output logic done
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] count;

  // Count register: clear on a new load, saturating increment otherwise;
  // done is set on the edge where the count arrives at WIDTH and then sticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      done  <= 1'b0;
    end else if (clr) begin
      count <= '0;
      done  <= 1'b0;
    end else if (incr && (count != CNT_MAX)) begin
      count <= count + 1'b1;
      if (count == CNT_LAST) begin
        done <= 1'b1;
      end
    end
  end

  // Status straight from the count register, no extra latency.
  always_comb begin
    less32 = (count < CNT_MAX);
  end

endmodule
`default_nettype wire

// File: rtl/seq_mul_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mul_datapath
//  Description : Shift-add datapath of the sequential unsigned multiplier.
//                Executes the control FSM's add/shr/incr strobes on the
//                multiplicand, the {carry, acc_hi, acc_lo} accumulator and
//                the iteration counter; returns product and status.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_mul_datapath
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wrt,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  input  logic               add,
  input  logic               shr,
  input  logic               incr,
  output logic               less32,
  output logic [2*WIDTH-1:0] product,
  output logic               done
);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic             carry;

  logic             add_en;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   post_add;

  // Conditional add of the multiplicand; post_add is {carry, acc_hi} as it
  // stands after this cycle's add, so a coincident shr shifts the new value.
  always_comb begin
    add_en   = add & acc_lo[0];
    sum      = {1'b0, acc_hi} + {1'b0, mcand};
    post_add = add_en ? sum : {carry, acc_hi};
  end

  // Operand/accumulator registers: load on wrt, otherwise add and/or shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      carry  <= 1'b0;
    end else if (wrt) begin
      mcand  <= a_in;
      acc_hi <= '0;
      acc_lo <= b_in;
      carry  <= 1'b0;
    end else if (shr) begin
      {carry, acc_hi, acc_lo} <= {1'b0, post_add, acc_lo[WIDTH-1:1]};
    end else begin
      {carry, acc_hi} <= post_add;
    end
  end

  // Product is presented directly from the accumulator registers.
  always_comb begin
    product = {acc_hi, acc_lo};
  end

  mul_iter_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_counter (
    .clk    (clk),
    .rst    (rst),
    .clr    (wrt),
    .incr   (incr),
    .less32 (less32),
    .done   (done)
  );

endmodule
`default_nettype wire

// File: tb/tb_seq_mul_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_mul_datapath
//  Description : Directed self-checking bench for seq_mul_datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_mul_datapath;

  logic        clk;
  logic        rst;
  logic        wrt;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        add;
  logic        shr;
  logic        incr;
  logic        less32;
  logic [63:0] product;
  logic        done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  seq_mul_datapath dut (
    .clk     (clk),
    .rst     (rst),
    .wrt     (wrt),
    .a_in    (a_in),
    .b_in    (b_in),
    .add     (add),
    .shr     (shr),
    .incr    (incr),
    .less32  (less32),
    .product (product),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs, let the edge happen, sample 1 ns later.
  task automatic step(input logic w, input logic [31:0] a, input logic [31:0] b,
                      input logic ad, input logic sh, input logic inc);
    wrt = w; a_in = a; b_in = b; add = ad; shr = sh; incr = inc;
    @(posedge clk);
    #1;
    wrt = 1'b0; add = 1'b0; shr = 1'b0; incr = 1'b0;
  endtask

  // One split round: add on one edge, shr+incr on the next.
  task automatic round();
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1; wrt = 1'b0; a_in = '0; b_in = '0; add = 1'b0; shr = 1'b0; incr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (product !== 64'd0) $display("FAIL reset_product actual=%h required=%h", product, 64'd0);
    else pass_cnt++;
    total_cnt++;
    if (less32 !== 1'b1 || done !== 1'b0)
      $display("FAIL reset_status actual less32=%b done=%b required less32=1 done=0", less32, done);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    step(1'b1, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (product !== 64'd5 || done !== 1'b0 || less32 !== 1'b1)
      $display("FAIL basic_load actual product=%h done=%b less32=%b required product=%h done=0 less32=1",
               product, done, less32, 64'd5);
    else pass_cnt++;
    for (int i = 0; i < 31; i++) round();
    total_cnt++;
    if (less32 !== 1'b1 || done !== 1'b0)
      $display("FAIL basic_round31 actual less32=%b done=%b required less32=1 done=0", less32, done);
    else pass_cnt++;
    round();
    total_cnt++;
    if (product !== 64'h0000_0000_0000_000F)
      $display("FAIL basic_product actual=%h required=%h", product, 64'h0000_0000_0000_000F);
    else pass_cnt++;
    total_cnt++;
    if (less32 !== 1'b0 || done !== 1'b1)
      $display("FAIL basic_done actual less32=%b done=%b required less32=0 done=1", less32, done);
    else pass_cnt++;
  endtask

  task automatic test_carry();
    step(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    round();
    // acc_hi is now 7FFF_FFFF; adding FFFF_FFFF must overflow into carry.
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    total_cnt++;
    if (dut.carry !== 1'b1) $display("FAIL carry_set actual=%b required=1", dut.carry);
    else pass_cnt++;
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    total_cnt++;
    if (dut.carry !== 1'b0) $display("FAIL carry_clear_on_shr actual=%b required=0", dut.carry);
    else pass_cnt++;
    for (int i = 0; i < 30; i++) round();
    total_cnt++;
    if (product !== 64'hFFFF_FFFE_0000_0001)
      $display("FAIL carry_product actual=%h required=%h", product, 64'hFFFF_FFFE_0000_0001);
    else pass_cnt++;
  endtask

  task automatic test_merged();
    step(1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1);
    total_cnt++;
    if (product !== 64'h0B00_EA4E_242D_2080 || done !== 1'b1)
      $display("FAIL merged_product actual=%h done=%b required=%h done=1",
               product, done, 64'h0B00_EA4E_242D_2080);
    else pass_cnt++;
    step(1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) round();
    total_cnt++;
    if (product !== 64'h0B00_EA4E_242D_2080)
      $display("FAIL split_product actual=%h required=%h", product, 64'h0B00_EA4E_242D_2080);
    else pass_cnt++;
  endtask

  task automatic test_restart();
    step(1'b1, 32'd7, 32'd9, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) round();
    step(1'b1, 32'd2, 32'd6, 1'b1, 1'b1, 1'b1);
    total_cnt++;
    if (product !== 64'd6 || done !== 1'b0 || less32 !== 1'b1 || dut.u_counter.count !== 6'd0)
      $display("FAIL restart_load actual product=%h done=%b less32=%b count=%0d required product=6 done=0 less32=1 count=0",
               product, done, less32, dut.u_counter.count);
    else pass_cnt++;
    for (int i = 0; i < 32; i++) round();
    total_cnt++;
    if (product !== 64'd12 || done !== 1'b1)
      $display("FAIL restart_product actual=%h done=%b required=%h done=1", product, done, 64'd12);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    step(1'b1, 32'd7, 32'd9, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) round();
    @(negedge clk);
    rst = 1'b1;
    #1;
    total_cnt++;
    if (product !== 64'd0 || less32 !== 1'b1 || done !== 1'b0 || dut.u_counter.count !== 6'd0)
      $display("FAIL async_reset actual product=%h less32=%b done=%b count=%0d required product=0 less32=1 done=0 count=0",
               product, less32, done, dut.u_counter.count);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 32'd4, 32'd4, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) round();
    total_cnt++;
    if (product !== 64'd16 || done !== 1'b1)
      $display("FAIL post_reset_product actual=%h done=%b required=%h done=1", product, done, 64'd16);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    step(1'b1, 32'd5, 32'd7, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 31; i++) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    total_cnt++;
    if (less32 !== 1'b1 || done !== 1'b0 || dut.u_counter.count !== 6'd31)
      $display("FAIL sat_31 actual less32=%b done=%b count=%0d required less32=1 done=0 count=31",
               less32, done, dut.u_counter.count);
    else pass_cnt++;
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    total_cnt++;
    if (less32 !== 1'b0 || done !== 1'b1 || dut.u_counter.count !== 6'd32)
      $display("FAIL sat_32 actual less32=%b done=%b count=%0d required less32=0 done=1 count=32",
               less32, done, dut.u_counter.count);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    total_cnt++;
    if (less32 !== 1'b0 || done !== 1'b1 || dut.u_counter.count !== 6'd32)
      $display("FAIL sat_35 actual less32=%b done=%b count=%0d required less32=0 done=1 count=32",
               less32, done, dut.u_counter.count);
    else pass_cnt++;
    total_cnt++;
    if (product !== 64'd7) $display("FAIL sat_product actual=%h required=%h", product, 64'd7);
    else pass_cnt++;
  endtask

  task automatic test_hold();
    for (int i = 0; i < 3; i++) step(1'b0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (product !== 64'd7 || done !== 1'b1 || less32 !== 1'b0)
      $display("FAIL idle_hold actual product=%h done=%b less32=%b required product=7 done=1 less32=0",
               product, done, less32);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_merged();
    test_restart();
    test_async_reset();
    test_saturation();
    test_hold();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
